regfile_write_arbiter: RTL and testbench

//   Shares the single register-file write port (RegWrite/EscReg/WriteData) between
//   NUM_REQ writeback sources, e.g. ALU, memory load and debug. Round-robin, one write per cycle.

---
 rtl/regfile_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ writeback sources.
// Optional read bypass of the in-flight write is enabled by defining RFARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         EscReg,
    output logic [DATA_W-1:0]         WriteData,
    output logic [2:0]                grant_id,
`ifdef RFARB_BYPASS_EN
    input  logic [2*ADDR_W-1:0]       byp_raddr,
    output logic [1:0]                byp_hit,
    output logic [DATA_W-1:0]         byp_data,
`endif
    output logic [7:0]                write_count
);

    localparam int unsigned NREQ_U = NUM_REQ;

    // Index reached 'off' steps after 'base', wrapping modulo NUM_REQ.
    function automatic logic [2:0] rr_next(input logic [2:0] base, input int unsigned off);
        int unsigned sum_v;
        sum_v = 32'(base) + off;
        return 3'(sum_v % NREQ_U);
    endfunction

    logic [2:0]         rr_ptr_q,      rr_ptr_d;
    logic               reg_write_q,   reg_write_d;
    logic [ADDR_W-1:0]  esc_reg_q,     esc_reg_d;
    logic [DATA_W-1:0]  write_data_q,  write_data_d;
    logic [2:0]         grant_id_q,    grant_id_d;
    logic [7:0]         write_count_q, write_count_d;

    logic [7:0]         valid_ext_s;
    logic               found_s;
    logic [2:0]         grant_idx_s;
    logic               transfer_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_data_s;

    assign valid_ext_s = 8'(req_valid);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [2:0] idx_v;
        idx_v       = 3'd0;
        found_s     = 1'b0;
        grant_idx_s = 3'd0;
        for (int unsigned off = 1; off <= NREQ_U; off++) begin
            idx_v = rr_next(rr_ptr_q, off);
            if (!found_s && valid_ext_s[idx_v]) begin
                found_s     = 1'b1;
                grant_idx_s = idx_v;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Grant is suppressed during reset so nothing is handshaken and dropped.
    always_comb begin
        transfer_s = found_s && reset_n;
        if (transfer_s) begin
            req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
        end else begin
            req_ready = '0;
        end
    end

    // Address/data mux for the granted requester.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == 3'(i)) begin
                sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
                sel_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Next-state for the write port, pointer and commit counter.
    always_comb begin
        reg_write_d   = 1'b0;
        esc_reg_d     = esc_reg_q;
        write_data_d  = write_data_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        write_count_d = write_count_q;
        if (transfer_s) begin
            reg_write_d  = (sel_addr_s != '0);
            esc_reg_d    = sel_addr_s;
            write_data_d = sel_data_s;
            grant_id_d   = grant_idx_s;
            rr_ptr_d     = grant_idx_s;
        end else begin
            reg_write_d  = 1'b0;
        end
        if (reg_write_d && (write_count_q != 8'hFF)) begin
            write_count_d = write_count_q + 8'd1;
        end else begin
            write_count_d = write_count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_q      <= 3'(NUM_REQ - 1);
            reg_write_q   <= 1'b0;
            esc_reg_q     <= '0;
            write_data_q  <= '0;
            grant_id_q    <= 3'd0;
            write_count_q <= 8'd0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            reg_write_q   <= reg_write_d;
            esc_reg_q     <= esc_reg_d;
            write_data_q  <= write_data_d;
            grant_id_q    <= grant_id_d;
            write_count_q <= write_count_d;
        end
    end

    assign RegWrite    = reg_write_q;
    assign EscReg      = esc_reg_q;
    assign WriteData   = write_data_q;
    assign grant_id    = grant_id_q;
    assign write_count = write_count_q;

`ifdef RFARB_BYPASS_EN
    // Forward the pending write to posedge readers ahead of the negedge commit.
    always_comb begin
        byp_data = write_data_q;
        for (int j = 0; j < 2; j++) begin
            byp_hit[j] = reg_write_q && (esc_reg_q == byp_raddr[j*ADDR_W +: ADDR_W])
                         && (esc_reg_q != '0);
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter; bypass vectors run when RFARB_BYPASS_EN is defined.
module tb_regfile_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;

    logic                      clock;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         EscReg;
    logic [DATA_W-1:0]         WriteData;
    logic [2:0]                grant_id;
    logic [7:0]                write_count;
`ifdef RFARB_BYPASS_EN
    logic [2*ADDR_W-1:0]       byp_raddr;
    logic [1:0]                byp_hit;
    logic [DATA_W-1:0]         byp_data;
`endif

    int vectors = 0;
    int errors  = 0;

    regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .RegWrite(RegWrite), .EscReg(EscReg),
        .WriteData(WriteData), .grant_id(grant_id),
`ifdef RFARB_BYPASS_EN
        .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
        .write_count(write_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11;
        exp_data[1] = 8'h22;
        exp_data[2] = 8'h33;

        reset_n   = 1'b0;
        req_valid = 3'b000;
        req_addr  = '0;
        req_data  = '0;
`ifdef RFARB_BYPASS_EN
        byp_raddr = '0;
`endif
        tick();
        tick();
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_escreg",   32'(EscReg),   32'd0);
        check("rst_wdata",    32'(WriteData), 32'd0);
        check("rst_grant",    32'(grant_id), 32'd0);
        check("rst_count",    32'(write_count), 32'd0);
        reset_n = 1'b1;

        // Test 1: lone requester 1, addr 3, data A5
        req_valid = 3'b010;
        req_addr[1*ADDR_W +: ADDR_W] = 3'd3;
        req_data[1*DATA_W +: DATA_W] = 8'hA5;
        #1;
        check("t1_ready", 32'(req_ready), 32'b010);
        tick();
        check("t1_regwrite", 32'(RegWrite), 32'd1);
        check("t1_escreg",   32'(EscReg),   32'd3);
        check("t1_wdata",    32'(WriteData), 32'hA5);
        check("t1_grant",    32'(grant_id), 32'd1);
        check("t1_count",    32'(write_count), 32'd1);
        req_valid = 3'b000;
        #1;
        check("idle_ready", 32'(req_ready), 32'd0);
        tick();
        check("idle_regwrite", 32'(RegWrite), 32'd0);
        check("idle_escreg_hold", 32'(EscReg), 32'd3);
        check("idle_wdata_hold", 32'(WriteData), 32'hA5);

        // Test 2: fresh reset, then all three valid for six cycles
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = 3'(i + 1);
            req_data[i*DATA_W +: DATA_W] = exp_data[i];
        end
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t2_ready", 32'(req_ready), 32'(3'b001 << (k % 3)));
            tick();
            check("t2_regwrite", 32'(RegWrite), 32'd1);
            check("t2_grant", 32'(grant_id), 32'(k % 3));
            check("t2_escreg", 32'(EscReg), 32'((k % 3) + 1));
            check("t2_wdata", 32'(WriteData), 32'(exp_data[k % 3]));
        end
        check("t2_count", 32'(write_count), 32'd6);
        req_valid = 3'b000;

        // Test 3: requester 2 writes reg 0 -- handshake but no commit
        req_addr[2*ADDR_W +: ADDR_W] = 3'd0;
        req_data[2*DATA_W +: DATA_W] = 8'hFF;
        req_valid = 3'b100;
        #1;
        check("t3_ready", 32'(req_ready), 32'b100);
        tick();
        check("t3_regwrite", 32'(RegWrite), 32'd0);
        check("t3_grant", 32'(grant_id), 32'd2);
        check("t3_count", 32'(write_count), 32'd6);
        req_valid = 3'b000;

        // Test 4: persistent requester 0 to reg 5 up to and beyond saturation
        req_addr[0 +: ADDR_W] = 3'd5;
        req_data[0 +: DATA_W] = 8'h5A;
        req_valid = 3'b001;
        for (int k = 0; k < 248; k++) begin
            tick();
        end
        check("t4_count_254", 32'(write_count), 32'd254);
        check("t4_persist_regwrite", 32'(RegWrite), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("t4_ready", 32'(req_ready), 32'b001);
            tick();
            check("t4_count_sat", 32'(write_count), 32'd255);
            check("t4_escreg", 32'(EscReg), 32'd5);
        end

        // Test 5: mid-stream reset with everyone valid
        req_valid = 3'b111;
        #1;
        check("t5_ready_pre", 32'(req_ready), 32'b010);
        tick();
        check("t5_grant_pre", 32'(grant_id), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t5_ready_in_rst", 32'(req_ready), 32'd0);
        tick();
        check("t5_regwrite_rst", 32'(RegWrite), 32'd0);
        check("t5_count_rst", 32'(write_count), 32'd0);
        check("t5_grant_rst", 32'(grant_id), 32'd0);
        reset_n = 1'b1;
        #1;
        check("t5_ready_post", 32'(req_ready), 32'b001);
        tick();
        check("t5_grant_post", 32'(grant_id), 32'd0);
        check("t5_regwrite_post", 32'(RegWrite), 32'd1);
        check("t5_wdata_post", 32'(WriteData), 32'h5A);
        check("t5_count_post", 32'(write_count), 32'd1);
        req_valid = 3'b000;
        tick();

`ifdef RFARB_BYPASS_EN
        // Test 6: bypass of an in-flight write to r4
        req_addr[1*ADDR_W +: ADDR_W] = 3'd4;
        req_data[1*DATA_W +: DATA_W] = 8'h3C;
        byp_raddr = {3'd4, 3'd4};
        req_valid = 3'b010;
        tick();
        req_valid = 3'b000;
        check("t6_hit", 32'(byp_hit), 32'b11);
        check("t6_data", 32'(byp_data), 32'h3C);
        tick();
        check("t6_hit_idle", 32'(byp_hit), 32'b00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
